// File: rtl/aidan_mcnay_debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aidan_mcnay_debounce_scheduler
// Brief    : Round-robin, time-multiplexed debouncer for N synchronised inputs
//            with registered levels and one-cycle rise/fall event pulses.
// Revision : 1.0 - initial release
// ============================================================================
module aidan_mcnay_debounce_scheduler #(
    parameter int N_INPUTS = 4,
    parameter int HIST_LEN = 4,
    parameter int TICK_DIV = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [N_INPUTS-1:0]         in,
    output logic [N_INPUTS-1:0]         out,
    output logic [N_INPUTS-1:0]         rise,
    output logic [N_INPUTS-1:0]         fall,
    output logic [$clog2(N_INPUTS)-1:0] slot,
    output logic                        strobe
);

    localparam int SW = $clog2(N_INPUTS);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] c_slot_last  = SW'(N_INPUTS - 1);

    logic [PW-1:0]                     presc_q, presc_d;
    logic [SW-1:0]                     slot_q,  slot_d;
    logic [N_INPUTS-1:0][HIST_LEN-1:0] hist_q,  hist_d;
    logic [N_INPUTS-1:0]               out_q,   out_d;
    logic [N_INPUTS-1:0]               rise_q,  rise_d;
    logic [N_INPUTS-1:0]               fall_q,  fall_d;
    logic                              w_tick;
    logic [HIST_LEN-1:0]               w_hist_new;

    assign w_tick = en && (presc_q == c_presc_last);

    always_comb begin
        presc_d    = presc_q;
        slot_d     = slot_q;
        hist_d     = hist_q;
        out_d      = out_q;
        rise_d     = '0;
        fall_d     = '0;
        w_hist_new = {hist_q[slot_q][HIST_LEN-2:0], in[slot_q]};

        if (en) begin
            presc_d = w_tick ? '0 : presc_q + 1'b1;
        end

        // Only the slot being sampled may update its history and level.
        if (w_tick) begin
            hist_d[slot_q] = w_hist_new;
            slot_d         = (slot_q == c_slot_last) ? '0 : slot_q + 1'b1;
            if ((&w_hist_new) && !out_q[slot_q]) begin
                out_d[slot_q]  = 1'b1;
                rise_d[slot_q] = 1'b1;
            end else if (!(|w_hist_new) && out_q[slot_q]) begin
                out_d[slot_q]  = 1'b0;
                fall_d[slot_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            slot_q  <= '0;
            hist_q  <= '0;
            out_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            hist_q  <= hist_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out    = out_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign slot   = slot_q;
    assign strobe = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_aidan_mcnay_debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aidan_mcnay_debounce_scheduler
// Brief    : Scoreboard bench: a run-length reference model predicts every
//            cycle's outputs, plus directed checks of the key timing points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aidan_mcnay_debounce_scheduler;

    localparam int NI = 4;
    localparam int HL = 4;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] in_v;
    logic [3:0] out_v;
    logic [3:0] rise_v;
    logic [3:0] fall_v;
    logic [1:0] slot_v;
    logic       strobe_v;

    always #5 clk = ~clk;

    aidan_mcnay_debounce_scheduler #(
        .N_INPUTS(NI),
        .HIST_LEN(HL),
        .TICK_DIV(TD)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .in     (in_v),
        .out    (out_v),
        .rise   (rise_v),
        .fall   (fall_v),
        .slot   (slot_v),
        .strobe (strobe_v)
    );

    typedef struct {
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] f;
        logic [1:0] s;
        logic       st;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    // Reference model: enabled-edge count plus per-input run length of equal samples.
    int         m_ecnt;
    logic [3:0] m_out;
    logic       m_last [NI];
    int         m_run  [NI];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [3:0] v, output exp_t x);
        int s;
        x.r = '0;
        x.f = '0;
        if (r) begin
            m_ecnt = 0;
            m_out  = '0;
            for (int i = 0; i < NI; i++) begin
                m_last[i] = 1'b0;
                m_run[i]  = HL;
            end
        end else if (e) begin
            if (m_ecnt % TD == TD - 1) begin
                s = (m_ecnt / TD) % NI;
                if (v[s] == m_last[s]) m_run[s]++;
                else begin
                    m_last[s] = v[s];
                    m_run[s]  = 1;
                end
                if (m_run[s] >= HL && m_out[s] != m_last[s]) begin
                    m_out[s] = m_last[s];
                    if (m_last[s]) x.r[s] = 1'b1;
                    else           x.f[s] = 1'b1;
                end
            end
            m_ecnt++;
        end
        x.o  = m_out;
        x.s  = 2'((m_ecnt / TD) % NI);
        x.st = e && (m_ecnt % TD == TD - 1);
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] v);
        exp_t x;
        exp_t y;
        @(negedge clk);
        reset = r;
        en    = e;
        in_v  = v;
        model_edge(r, e, v, x);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        edge_n = r ? 0 : edge_n + 1;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            y = sb_q.pop_front();
            check_val("sb_out",    32'(out_v),    32'(y.o));
            check_val("sb_rise",   32'(rise_v),   32'(y.r));
            check_val("sb_fall",   32'(fall_v),   32'(y.f));
            check_val("sb_slot",   32'(slot_v),   32'(y.s));
            check_val("sb_strobe", 32'(strobe_v), 32'(y.st));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_pulse;
        reset = 1'b1;
        en    = 1'b0;
        in_v  = '0;

        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0000);
        check_val("rst_out",    32'(out_v),    32'd0);
        check_val("rst_slot",   32'(slot_v),   32'd0);
        check_val("rst_strobe", 32'(strobe_v), 32'd0);

        // in[0] held high; in[1] pulses only for the slot-1 sample at edge 8.
        for (int e = 1; e <= 56; e++) begin
            step(1'b0, 1'b1, (e == 8) ? 4'b0011 : 4'b0001);
            if (e == 3)  check_val("t1_strobe_e3", 32'(strobe_v), 32'd1);
            if (e == 4)  check_val("t1_strobe_e4", 32'(strobe_v), 32'd0);
            if (e == 51) check_val("t1_out_e51",   32'(out_v[0]), 32'd0);
            if (e == 52) check_val("t1_out_e52",   32'(out_v[0]), 32'd1);
            if (e == 52) check_val("t1_rise_e52",  32'(rise_v),   32'b0001);
            if (e == 53) check_val("t1_rise_e53",  32'(rise_v),   32'd0);
        end
        check_val("t2_out_hi", 32'(out_v[3:1]), 32'd0);

        // in[0] drops: slot-0 samples at 68, 84, 100, 116.
        for (int e = 57; e <= 122; e++) begin
            step(1'b0, 1'b1, 4'b0000);
            if (e == 115) check_val("t3_out_e115",  32'(out_v[0]), 32'd1);
            if (e == 116) check_val("t3_out_e116",  32'(out_v[0]), 32'd0);
            if (e == 116) check_val("t3_fall_e116", 32'(fall_v),   32'b0001);
            if (e == 117) check_val("t3_fall_e117", 32'(fall_v),   32'd0);
        end
        check_val("t4_slot_pre", 32'(slot_v), 32'd2);

        for (int c = 0; c < 30; c++) begin
            step(1'b0, 1'b0, 4'b1111);
            check_val("t4_pulses", 32'(rise_v | fall_v), 32'd0);
            check_val("t4_slot",   32'(slot_v),          32'd2);
        end
        step(1'b0, 1'b1, 4'b1111);
        check_val("t4_resume_strobe", 32'(strobe_v), 32'd1);
        check_val("t4_resume_slot",   32'(slot_v),   32'd2);
        step(1'b0, 1'b1, 4'b1111);
        check_val("t4_next_slot", 32'(slot_v), 32'd3);

        for (int c = 0; c < 80; c++) step(1'b0, 1'b1, 4'b1111);
        while (m_ecnt % TD != TD - 1) step(1'b0, 1'b1, 4'b1111);
        check_val("t5_out_all", 32'(out_v),    32'b1111);
        check_val("t5_presc3",  32'(strobe_v), 32'd1);
        step(1'b1, 1'b1, 4'b1111);
        check_val("t5_rst_out",    32'(out_v),    32'd0);
        check_val("t5_rst_slot",   32'(slot_v),   32'd0);
        check_val("t5_rst_fall",   32'(fall_v),   32'd0);
        check_val("t5_rst_strobe", 32'(strobe_v), 32'd0);
        for (int e = 1; e <= 52; e++) begin
            step(1'b0, 1'b1, 4'b1111);
            if (e == 51) check_val("t5_re_e51", 32'(out_v), 32'd0);
            if (e == 52) check_val("t5_re_e52", 32'(out_v), 32'b0001);
        end

        // Toggle every cycle; sampling edges are all even and see 0.
        step(1'b1, 1'b1, 4'b0000);
        any_pulse = 1'b0;
        for (int e = 1; e <= 500; e++) begin
            step(1'b0, 1'b1, (e % 2 == 1) ? 4'b1111 : 4'b0000);
            if ((rise_v | fall_v) != 4'd0) any_pulse = 1'b1;
        end
        check_val("t6_out",    32'(out_v),     32'd0);
        check_val("t6_pulses", 32'(any_pulse), 32'd0);

        // Random stimulus with en gaps and rare resets, checked by the model.
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 4'($urandom_range(0, 15)));
            check_val("rand_onehot", 32'($countones(rise_v | fall_v) <= 1), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
